// File: rtl/inv_pipe.sv
// inv_pipe: registered, mask-selective word inverter (Y = A ^ MASK)
// carried through a DEPTH-stage valid/ready pipeline with full backpressure.
//
// Optional build macro INV_PIPE_PARITY_EN adds Y_PAR. Y_PAR is the XOR-reduce
// of the word, computed at acceptance and kept aligned with Y.
//
// The design has no state machine. Each stage holds only its valid bit and
// its data register.

module inv_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] MASK,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] Y,
    output logic             OUT_VALID,
`ifdef INV_PIPE_PARITY_EN
    output logic             Y_PAR,
`endif
    input  logic             OUT_READY
);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] r;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];
    logic [WIDTH-1:0] acc_word;

    assign acc_word = A ^ MASK;

`ifdef INV_PIPE_PARITY_EN
    logic [DEPTH-1:0] p;
    logic [DEPTH-1:0] up_p;
`endif

    // Ready chain, written in its unrolled form.
    // A stage may load when it, or any stage downstream of it, is empty,
    // or when the output is being consumed.
    always_comb begin
        logic any_empty;
        any_empty = 1'b0;
        r         = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            any_empty = any_empty | ~v[k];
            r[k]      = OUT_READY | any_empty;
        end
    end

    // Upstream view of each stage: stage 0 sees the accepted word, the
    // other stages see their predecessor.
    always_comb begin
        up_v    = '0;
        up_v[0] = IN_VALID;
        up_d[0] = acc_word;
        for (int k = 1; k < DEPTH; k++) begin
            up_v[k] = v[k-1];
            up_d[k] = d[k-1];
        end
    end

`ifdef INV_PIPE_PARITY_EN
    // Parity travels next to the data, so Y_PAR always matches Y.
    always_comb begin
        up_p    = '0;
        up_p[0] = ^acc_word;
        for (int k = 1; k < DEPTH; k++) begin
            up_p[k] = p[k-1];
        end
    end
`endif

    // Stage registers.
    // A data register loads only when a valid word arrives, so empty stages
    // never disturb Y.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (RST) begin
                v[k] <= 1'b0;
                d[k] <= '0;
            end else if (r[k]) begin
                v[k] <= up_v[k];
                if (up_v[k]) begin
                    d[k] <= up_d[k];
                end
            end
        end
    end

`ifdef INV_PIPE_PARITY_EN
    // Parity registers follow the same load enable as the data registers.
    always_ff @(posedge CLK) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (RST) begin
                p[k] <= 1'b0;
            end else if (r[k] && up_v[k]) begin
                p[k] <= up_p[k];
            end
        end
    end

    assign Y_PAR = p[DEPTH-1];
`endif

    assign IN_READY  = r[0];
    assign OUT_VALID = v[DEPTH-1];
    assign Y         = d[DEPTH-1];

endmodule

// File: doc/inv_pipe.md
Name: inv_pipe

Overview:
- Parametrised, registered successor to the single-bit inverter.
- Inverts a WIDTH-bit word bit-selectively under a per-bit MASK: Y = A XOR MASK.
- Carries the result through a DEPTH-stage valid/ready pipeline with full backpressure.
- Used wherever bus-polarity correction is needed on a streaming datapath, at one word per cycle.

Parameters:
- WIDTH, 8: data width in bits, >=1.
- DEPTH, 2: number of register stages, >=1. Sets the latency in cycles.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- A  input  WIDTH  input data word.
- MASK  input  WIDTH  per-bit invert select (1 = invert, 0 = pass through); sampled with A.
- IN_VALID  input  1  A/MASK valid this cycle.
- IN_READY  output  1  pipeline can accept a word this cycle.
- Y  output  WIDTH  output word, equal to A XOR MASK as accepted.
- OUT_VALID  output  1  Y is valid.
- OUT_READY  input  1  downstream accepts Y this cycle.

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous and active-high.
  - While RST=1 at a rising edge, every stage valid bit clears and every stage data register clears to 0.
  - After reset: OUT_VALID=0, Y=0, IN_READY=1.
- Transfers: input transfer occurs when IN_VALID & IN_READY. Output transfer occurs when OUT_VALID & OUT_READY.
- Function: A XOR MASK is computed combinationally at acceptance and written into stage 0. MASK is not used at any other time.
- Stages: stage k (0..DEPTH-1) holds v[k] and d[k]. Stage DEPTH-1 drives OUT_VALID=v[DEPTH-1] and Y=d[DEPTH-1].
- Ready chain:
  - r[DEPTH] = OUT_READY.
  - r[k] = ~v[k] | r[k+1].
  - IN_READY = r[0].
  - The chain is purely combinational, so a full pipeline accepts a new word in the same cycle the output is consumed.
- Stage update, when r[k]=1:
  - v[k] <= upstream valid (IN_VALID for k=0, else v[k-1]).
  - d[k] <= upstream data.
  - When r[k]=0, the stage holds.
- Latency and throughput:
  - Latency is exactly DEPTH cycles from input transfer to OUT_VALID, with OUT_READY held 1.
  - Sustained throughput is 1 word/cycle.
- Capacity: DEPTH words. Empty stages (bubbles) collapse under backpressure, so a stalled output still lets upstream stages fill.
- Stall stability: while OUT_VALID=1 and OUT_READY=0, Y and OUT_VALID stay stable. Words are never dropped, duplicated or reordered.
- Full pipeline: all v=1 with OUT_READY=0 gives IN_READY=0. With OUT_READY=1 in the same cycle, IN_READY=1 and the pipeline advances one slot.
- Input side: IN_VALID=1 with IN_READY=0 has no effect. Upstream must hold A/MASK stable until accepted.
- Reset mid-operation: all in-flight words are discarded and never appear on Y. RST overrides IN_VALID in the same cycle.
- Data registers of empty stages: don't-care functionally, but they must not toggle Y when v[DEPTH-1]=0, other than on reset.
- No state machine beyond the per-stage valid bits. No X propagation from the reset state.

Optional Feature:
- Macro: INV_PIPE_PARITY_EN.
- Defined:
  - Extra output port Y_PAR (output, 1 bit) gives the even parity (XOR-reduce) of Y.
  - Computed at input acceptance from A XOR MASK and carried in a parallel 1-bit register per stage under the same valid/ready control.
  - Y_PAR resets to 0 and is always aligned with Y.
- Undefined: the Y_PAR port and its registers do not exist. All other behaviour is identical.

Test Plan:
- Reset: RST=1 for 2 cycles with IN_VALID=1, A=0xFF -> OUT_VALID=0, Y=0x00, IN_READY=1 after release, and no output word appears.
- Latency/function (WIDTH=8, DEPTH=2): A=0x5A, MASK=0xFF accepted at cycle t, OUT_READY=1 -> OUT_VALID=1 only at cycle t+2, Y=0xA5.
- Mask modes:
  - A=0x0F, MASK=0xF0 -> Y=0xFF.
  - A=0x3C, MASK=0x00 -> Y=0x3C.
  - Issued back-to-back -> two consecutive output cycles.
- Backpressure:
  - OUT_READY=0, stream A=0x01,0x02,0x03,0x04 with MASK=0xFF -> IN_READY drops after 2 accepts, Y holds 0xFE stable.
  - Then OUT_READY=1 -> outputs 0xFE,0xFD,0xFC,0xFB in order, no gaps once flowing, no loss or duplication.
- Reset mid-stream: 2 words in flight, RST=1 for 1 cycle -> next cycle OUT_VALID=0, and neither word is ever output.
- Parity (INV_PIPE_PARITY_EN defined): A=0x01, MASK=0x00 -> Y_PAR=1. A=0x03, MASK=0x00 -> Y_PAR=0. A=0x00, MASK=0x07 -> Y=0x07, Y_PAR=1.
